// File: rtl/seq_serializer.sv
// seq_serializer: MSB-first parallel-to-serial converter with a one-word holding buffer for gapless streaming
module seq_serializer #(
  parameter int   WIDTH    = 8,
  parameter logic IDLE_BIT = 1'b0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             dout,
  output logic             dout_valid,
  output logic             word_done
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  typedef enum logic [1:0] {IDLE = 2'b01, SHIFT = 2'b10} state_t;
  state_t           state, state_nxt;
  logic [WIDTH-1:0] hold_reg, hold_nxt, sreg, sreg_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic             hold_full, hold_full_nxt, word_done_nxt;
  logic             handshake, shifting, last, start;
  // next state: any encoding other than SHIFT that is not starting a word falls back to IDLE
  always_comb begin
    handshake     = load_valid && !hold_full;
    shifting      = state == SHIFT;
    last          = cnt == LAST;
    start         = hold_full && (state == IDLE || (shifting && last));
    state_nxt     = (start || (shifting && !last)) ? SHIFT : IDLE;
    sreg_nxt      = start ? hold_reg : shifting ? {sreg[WIDTH-2:0], 1'b0} : sreg;
    cnt_nxt       = start ? '0 : shifting ? cnt + CW'(1) : cnt;
    hold_full_nxt = handshake ? 1'b1 : start ? 1'b0 : hold_full;
    hold_nxt      = handshake ? load_data : hold_reg;
    word_done_nxt = shifting && last;
  end
  // state and datapath registers, cleared asynchronously so a partial or held word is discarded
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      sreg      <= '0;
      cnt       <= '0;
      hold_reg  <= '0;
      hold_full <= 1'b0;
      word_done <= 1'b0;
    end else begin
      state     <= state_nxt;
      sreg      <= sreg_nxt;
      cnt       <= cnt_nxt;
      hold_reg  <= hold_nxt;
      hold_full <= hold_full_nxt;
      word_done <= word_done_nxt;
    end
  end
  assign load_ready = !hold_full;
  assign dout_valid = state == SHIFT;
  assign dout       = dout_valid ? sreg[WIDTH-1] : IDLE_BIT;
endmodule
